instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : IF stage and IF/ID register with a stall buffer and branch drain.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [15:0] bubble_cnt
);

    localparam logic [1:0]  c_FETCH   = 2'd0;
    localparam logic [1:0]  c_HOLD    = 2'd1;
    localparam logic [1:0]  c_DRAIN   = 2'd2;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect;
    logic [31:0] r_hold_buf;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic [15:0] r_bubble_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_redirect_nxt;
    logic [31:0] w_hold_buf_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc4_nxt;
    logic [15:0] w_bubble_cnt_nxt;
    logic        w_bubble;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_FETCH;
            r_pc         <= RESET_PC;
            r_redirect   <= 32'd0;
            r_hold_buf   <= 32'd0;
            r_id_instr   <= NOP;
            r_id_pc4     <= 32'd0;
            r_bubble_cnt <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redirect   <= w_redirect_nxt;
            r_hold_buf   <= w_hold_buf_nxt;
            r_id_instr   <= w_id_instr_nxt;
            r_id_pc4     <= w_id_pc4_nxt;
            r_bubble_cnt <= w_bubble_cnt_nxt;
        end
    end

    // Branch outranks stall; every branch cycle pushes a bubble into ID.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = r_redirect;
        w_hold_buf_nxt = r_hold_buf;
        w_id_instr_nxt = r_id_instr;
        w_id_pc4_nxt   = r_id_pc4;
        w_bubble       = 1'b0;

        case (r_state)
            c_FETCH: begin
                if (branch) begin
                    w_bubble = 1'b1;
                    if (imem_ack) begin
                        w_pc_nxt = branch_target;
                    end else begin
                        w_redirect_nxt = branch_target;
                        w_state_nxt    = c_DRAIN;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        w_hold_buf_nxt = imem_rdata;
                        w_pc_nxt       = w_pc_plus4;
                        w_state_nxt    = c_HOLD;
                    end
                end else if (imem_ack) begin
                    w_id_instr_nxt = imem_rdata;
                    w_id_pc4_nxt   = w_pc_plus4;
                    w_pc_nxt       = w_pc_plus4;
                end else begin
                    w_bubble = 1'b1;
                end
            end
            c_HOLD: begin
                if (branch) begin
                    w_bubble    = 1'b1;
                    w_pc_nxt    = branch_target;
                    w_state_nxt = c_FETCH;
                end else if (!stall) begin
                    // PC already advanced past the buffered word when it was captured.
                    w_id_instr_nxt = r_hold_buf;
                    w_id_pc4_nxt   = r_pc;
                    w_state_nxt    = c_FETCH;
                end
            end
            c_DRAIN: begin
                w_bubble = branch || !stall;
                if (branch) begin
                    w_redirect_nxt = branch_target;
                end
                if (imem_ack) begin
                    w_pc_nxt    = branch ? branch_target : r_redirect;
                    w_state_nxt = c_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_FETCH;
            end
        endcase

        if (w_bubble) begin
            w_id_instr_nxt = NOP;
            w_id_pc4_nxt   = 32'd0;
        end
    end

    always_comb begin
        w_bubble_cnt_nxt = r_bubble_cnt;
        if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
            w_bubble_cnt_nxt = r_bubble_cnt + 16'd1;
        end
    end

    always_comb begin
        imem_req   = !rst && (r_state != c_HOLD);
        imem_addr  = r_pc;
        id_instr   = r_id_instr;
        id_pc4     = r_id_pc4;
        bubble_cnt = r_bubble_cnt;
        if ((r_state == c_FETCH) && imem_ack) begin
            if_instr = imem_rdata;
        end else if (r_state == c_HOLD) begin
            if_instr = r_hold_buf;
        end else begin
            if_instr = NOP;
        end
    end

endmodule
`default_nettype wire
